// File: rtl/hazard_unit.sv
// Pipeline hazard controller: operand forwarding, load-use and branch hazard
// stall/flush control, data-memory wait FSM with timeout watchdog, event counters.
module hazard_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [1:0]       ResultSrcE,
  input  logic             PCSrcE,
  input  logic [4:0]       RdM,
  input  logic             RegWriteM,
  input  logic [4:0]       RdW,
  input  logic             RegWriteW,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic             MemTimeout,
  output logic [CNT_W-1:0] StallCount,
  output logic [CNT_W-1:0] FlushCount,
  output logic [1:0]       DbgState
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_WAIT  = 2'd1,
    ST_ERROR = 2'd2
  } state_e;

  // wait_cnt holds the number of not-ready cycles already elapsed, so the
  // trip compare is the same in RUN (count 0) and WAIT.
  localparam logic [15:0] TRIP = 16'(MEM_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [15:0]      wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lw_stall;
  logic             mem_stall;
  logic             trip;

  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = 2'b00;
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      sel = 2'b10;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      sel = 2'b01;
    return sel;
  endfunction

  assign ForwardAE = fwd_sel(Rs1E);
  assign ForwardBE = fwd_sel(Rs2E);

  assign lw_stall  = (ResultSrcE == 2'b01) && (RdE != 5'd0) &&
                     ((RdE == Rs1D) || (RdE == Rs2D));
  assign mem_stall = MemReqM && !MemReadyM;
  assign trip      = mem_stall && (wait_cnt_q == TRIP);

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_RUN: begin
        wait_cnt_d = 16'd0;
        if (trip) begin
          state_d = ST_ERROR;
        end else if (mem_stall) begin
          state_d    = ST_WAIT;
          wait_cnt_d = 16'd1;
        end
      end
      ST_WAIT: begin
        if (trip) begin
          state_d = ST_ERROR;
        end else if (mem_stall) begin
          wait_cnt_d = wait_cnt_q + 16'd1;
        end else begin
          state_d    = ST_RUN;
          wait_cnt_d = 16'd0;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = 16'd0;
      end
    endcase
  end

  // A frozen Execute stage re-presents a pending branch or load bubble, so
  // suppressing FlushD/FlushE during a memory wait defers them rather than losing them.
  always_comb begin
    StallF = 1'b0;
    StallD = 1'b0;
    StallE = 1'b0;
    StallM = 1'b0;
    FlushD = 1'b0;
    FlushE = 1'b0;
    FlushW = 1'b0;
    if (state_q == ST_ERROR || mem_stall) begin
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else begin
      StallF = lw_stall;
      StallD = lw_stall;
      FlushD = PCSrcE;
      FlushE = lw_stall | PCSrcE;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (StallF && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (FlushE && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= 16'd0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign MemTimeout = (state_q == ST_ERROR);
  assign StallCount = stall_cnt_q;
  assign FlushCount = flush_cnt_q;
  assign DbgState   = state_q;

endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit with a short watchdog and 4-bit counters
// so timeout and saturation are reachable quickly.
module tb_hazard_unit;

  localparam int unsigned TMO = 4;
  localparam int unsigned CW  = 4;

  // Packed output word: {FwdA[1:0], FwdB[1:0], StallF, StallD, StallE, StallM,
  // FlushD, FlushE, FlushW, MemTimeout}
  localparam logic [11:0] E_ZERO = 12'h000;
  localparam logic [11:0] E_LW   = 12'h0C4;
  localparam logic [11:0] E_BR   = 12'h00C;
  localparam logic [11:0] E_LWBR = 12'h0CC;
  localparam logic [11:0] E_MEM  = 12'h0F2;
  localparam logic [11:0] E_ERR  = 12'h0F3;

  localparam logic [31:0] S_RUN   = 32'd0;
  localparam logic [31:0] S_WAIT  = 32'd1;
  localparam logic [31:0] S_ERROR = 32'd2;

  logic          clk;
  logic          rst;
  logic [4:0]    Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0]    ResultSrcE;
  logic          PCSrcE, RegWriteM, RegWriteW, MemReqM, MemReadyM;
  logic [1:0]    ForwardAE, ForwardBE;
  logic          StallF, StallD, StallE, StallM;
  logic          FlushD, FlushE, FlushW, MemTimeout;
  logic [CW-1:0] StallCount, FlushCount;
  logic [1:0]    DbgState;
  logic [11:0]   outs;

  logic [11:0]   exp_q[$];
  int            n_vec;
  int            n_err;

  hazard_unit #(.MEM_TIMEOUT(TMO), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .ResultSrcE(ResultSrcE), .PCSrcE(PCSrcE),
    .RdM(RdM), .RegWriteM(RegWriteM), .RdW(RdW), .RegWriteW(RegWriteW),
    .MemReqM(MemReqM), .MemReadyM(MemReadyM),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
    .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
    .MemTimeout(MemTimeout), .StallCount(StallCount), .FlushCount(FlushCount),
    .DbgState(DbgState)
  );

  assign outs = {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
                 FlushD, FlushE, FlushW, MemTimeout};

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0; RdE = 5'd0;
    RdM = 5'd0; RdW = 5'd0; ResultSrcE = 2'b00; PCSrcE = 1'b0;
    RegWriteM = 1'b0; RegWriteW = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
  endtask

  // Inputs are already set; push the expectation, sample mid-cycle, then
  // advance to 1 ns past the next rising edge.
  task automatic apply(input string tag, input logic [11:0] exp);
    logic [11:0] e;
    exp_q.push_back(exp);
    @(negedge clk);
    e = exp_q.pop_front();
    check_val(tag, {20'd0, outs}, {20'd0, e});
    @(posedge clk);
    #1;
  endtask

  task automatic check_regs(input string tag, input logic [31:0] st,
                            input logic [31:0] sc, input logic [31:0] fc);
    check_val({tag, "_state"}, 32'(DbgState), st);
    check_val({tag, "_stallcnt"}, 32'(StallCount), sc);
    check_val({tag, "_flushcnt"}, 32'(FlushCount), fc);
  endtask

  function automatic logic [1:0] fwd_exp(input logic wm, input logic [4:0] rdm,
                                         input logic ww, input logic [4:0] rdw,
                                         input logic [4:0] rs);
    if (wm && rdm != 5'd0 && rdm == rs) return 2'b10;
    if (ww && rdw != 5'd0 && rdw == rs) return 2'b01;
    return 2'b00;
  endfunction

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    clear_inputs();
    #1;
    check_val("reset_outs", {20'd0, outs}, 32'd0);
    check_regs("reset", S_RUN, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b0;
    @(posedge clk);
    #1;

    // forwarding, directed
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; RegWriteW = 1'b1; RdW = 5'd5;
    apply("fwd_mem_wins", 12'h800);
    clear_inputs();
    RegWriteM = 1'b1; RegWriteW = 1'b1;
    apply("fwd_x0", E_ZERO);
    clear_inputs();
    RegWriteW = 1'b1; RdW = 5'd7; Rs2E = 5'd7;
    apply("fwd_wb_b", 12'h100);
    clear_inputs();

    // forwarding, random with a small register range so matches are common
    for (int i = 0; i < 24; i++) begin
      RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1));
      RdM  = 5'($urandom_range(0, 3));
      RdW  = 5'($urandom_range(0, 3));
      Rs1E = 5'($urandom_range(0, 3));
      Rs2E = 5'($urandom_range(0, 3));
      apply("fwd_rand", {fwd_exp(RegWriteM, RdM, RegWriteW, RdW, Rs1E),
                         fwd_exp(RegWriteM, RdM, RegWriteW, RdW, Rs2E), 8'h00});
    end
    clear_inputs();
    check_regs("after_fwd", S_RUN, 32'd0, 32'd0);

    // load-use
    ResultSrcE = 2'b01; RdE = 5'd3; Rs2D = 5'd3;
    apply("lw_use", E_LW);
    clear_inputs();
    apply("lw_gone", E_ZERO);
    check_regs("lw", S_RUN, 32'd1, 32'd1);
    ResultSrcE = 2'b01; RdE = 5'd0;
    apply("lw_x0", E_ZERO);
    ResultSrcE = 2'b10; RdE = 5'd4; Rs1D = 5'd4;
    apply("non_load", E_ZERO);
    clear_inputs();

    // branch, with and without a simultaneous load-use
    ResultSrcE = 2'b01; RdE = 5'd9; Rs1D = 5'd9; PCSrcE = 1'b1;
    apply("lw_branch", E_LWBR);
    clear_inputs();
    PCSrcE = 1'b1;
    apply("branch", E_BR);
    clear_inputs();
    check_regs("branch", S_RUN, 32'd2, 32'd3);

    // memory wait of 3 cycles; branch and load bubble deferred to the ready cycle
    MemReqM = 1'b1;
    apply("mem_wait1", E_MEM);
    PCSrcE = 1'b1;
    apply("mem_wait2", E_MEM);
    ResultSrcE = 2'b01; RdE = 5'd3; Rs2D = 5'd3;
    apply("mem_wait3", E_MEM);
    check_val("mem_in_wait", 32'(DbgState), S_WAIT);
    MemReadyM = 1'b1;
    apply("mem_ready", E_LWBR);
    clear_inputs();
    check_regs("mem_done", S_RUN, 32'd6, 32'd4);

    // N-1 not-ready cycles must not trip
    MemReqM = 1'b1;
    for (int i = 0; i < TMO - 1; i++) apply("mem_short", E_MEM);
    MemReadyM = 1'b1;
    apply("mem_short_done", E_ZERO);
    clear_inputs();
    check_regs("no_trip", S_RUN, 32'd9, 32'd4);

    // N not-ready cycles trip the watchdog
    MemReqM = 1'b1;
    for (int i = 0; i < TMO; i++) apply("mem_long", E_MEM);
    check_val("tmo_state", 32'(DbgState), S_ERROR);
    MemReadyM = 1'b1;
    apply("err_ready", E_ERR);
    clear_inputs();
    PCSrcE = 1'b1; RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
    apply("err_fwd", 12'h8F3);
    clear_inputs();
    for (int i = 0; i < 3; i++) apply("err_hold", E_ERR);
    check_regs("err_sat", S_ERROR, 32'd15, 32'd4);

    // asynchronous reset out of ERROR, away from any clock edge
    #2 rst = 1'b1;
    #1;
    check_val("arst_err_outs", {20'd0, outs}, 32'd0);
    check_regs("arst_err", S_RUN, 32'd0, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // asynchronous reset in the middle of a wait
    MemReqM = 1'b1;
    apply("wait_a", E_MEM);
    apply("wait_b", E_MEM);
    check_val("wait_state", 32'(DbgState), S_WAIT);
    #2 rst = 1'b1;
    #1;
    check_val("arst_wait_outs", {20'd0, outs}, {20'd0, E_MEM});
    check_regs("arst_wait", S_RUN, 32'd0, 32'd0);
    rst = 1'b0;
    clear_inputs();
    @(posedge clk);
    #1;
    check_regs("post_rst", S_RUN, 32'd0, 32'd0);

    // saturation of both counters
    ResultSrcE = 2'b01; RdE = 5'd6; Rs1D = 5'd6;
    for (int i = 0; i < 20; i++) apply("sat_lw", E_LW);
    clear_inputs();
    check_regs("sat", S_RUN, 32'd15, 32'd15);
    apply("sat_idle", E_ZERO);
    check_regs("sat_hold", S_RUN, 32'd15, 32'd15);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_unit.md
# hazard_unit

Pipeline hazard controller for the five-stage RISC-V core. It consumes the register indices and control bits latched by the ID/EX, EX/MEM and MEM/WB stage registers. It returns the forwarding selects, the stage stall enables and the flush/CLR strobes that those registers obey, including the CLR input of the execute register. It also owns a data-memory wait state machine with a timeout watchdog, plus saturating stall and flush event counters.

## Interface
- MEM_TIMEOUT, 16: maximum consecutive data-memory wait cycles before the timeout trips; legal range 1 to 2^16-1.
- CNT_W, 32: width of the event counters.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- Rs1D, Rs2D  in  5 each  source registers of the instruction in Decode.
- Rs1E, Rs2E, RdE  in  5 each  source and destination registers in Execute.
- ResultSrcE  in  2  result select in Execute; 2'b01 means load.
- PCSrcE  in  1  taken branch or jump resolved in Execute.
- RdM, RegWriteM  in  5, 1  destination register and write enable in Memory.
- RdW, RegWriteW  in  5, 1  destination register and write enable in Writeback.
- MemReqM  in  1  Memory stage holds a load or store.
- MemReadyM  in  1  data memory completes the access this cycle.
- ForwardAE, ForwardBE  out  2 each  ALU operand source: 00 register file, 10 ALU result from Memory, 01 result from Writeback.
- StallF, StallD, StallE, StallM  out  1 each  hold the PC, IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushW  out  1 each  clear IF/ID, ID/EX (CLR) and MEM/WB.
- MemTimeout  out  1  sticky watchdog flag.
- StallCount, FlushCount  out  CNT_W each  saturating event counters.

## Operation
- Forwarding, per operand (shown for A; B is identical with Rs2E):
  - 10 if RegWriteM && RdM!=0 && RdM==Rs1E.
  - Otherwise 01 if RegWriteW && RdW!=0 && RdW==Rs1E.
  - Otherwise 00. Memory stage wins when both match.
- lwStall = (ResultSrcE==2'b01) && RdE!=0 && (RdE==Rs1D || RdE==Rs2D).
- memStall = MemReqM && !MemReadyM.
- FSM states:
  - RUN → WAIT when memStall.
  - WAIT → RUN when !memStall.
  - WAIT → ERROR when memStall and wait_cnt == MEM_TIMEOUT-1.
  - ERROR is absorbing; only rst leaves it.
- wait_cnt (16 bit):
  - Cleared in RUN.
  - Incremented each WAIT cycle with memStall.
  - Cleared on WAIT→RUN.
- Output priority, highest first:
  - ERROR: all four stalls = 1, FlushW = 1, FlushD = FlushE = 0, MemTimeout = 1.
  - memStall, in any state: StallF/D/E/M = 1, FlushW = 1, FlushD = FlushE = 0. The branch flush and the load bubble are deferred, not lost, because Execute is frozen and the condition re-presents itself.
  - Otherwise:
    - StallF = StallD = lwStall.
    - StallE = StallM = 0.
    - FlushD = PCSrcE.
    - FlushE = lwStall | PCSrcE.
    - FlushW = 0.
- lwStall and PCSrcE together: stall F/D and flush both D and E. The flush dominates, and the redirected fetch proceeds on the next cycle.
- Counters:
  - StallCount += 1 on each cycle StallF is 1.
  - FlushCount += 1 on each cycle FlushE is 1.
  - Both saturate at all-ones and never wrap.

## Timing
- Forwarding, stall and flush outputs are combinational from the current inputs and state, with zero-cycle latency. Stage registers sample them at the same edge.
- MemTimeout, counters and state are registered and change one edge after the triggering cycle.
- Reset values:
  - State RUN, wait_cnt 0, MemTimeout 0, StallCount 0, FlushCount 0.
  - Combinational outputs follow inputs; with all inputs zero, every output is 0.
- rst asserted mid-WAIT or in ERROR returns the FSM to RUN immediately (asynchronous) and clears the counters and the flag.
- With MEM_TIMEOUT = N, a request held not-ready for N consecutive cycles enters ERROR at the edge ending the Nth cycle. N-1 cycles does not.

## Test plan
- Forwarding:
  - RegWriteM=1, RdM=5, Rs1E=5, with RegWriteW=1, RdW=5 also set → ForwardAE=10.
  - RdM=0, Rs1E=0 → ForwardAE=00.
  - RdW=7=Rs2E only → ForwardBE=01.
- Load-use: ResultSrcE=01, RdE=3, Rs2D=3 → StallF=StallD=FlushE=1 for one cycle; StallCount increments by 1. RdE=0 → no stall.
- Branch: PCSrcE=1 with lwStall=1 → FlushD=FlushE=1, StallF=1; FlushCount +1.
- Memory wait: MemReqM=1, MemReadyM=0 for 3 cycles, then 1 → StallF/D/E/M=FlushW=1 for exactly 3 cycles. PCSrcE=1 during the wait gives FlushE=0. State returns to RUN and MemTimeout stays 0.
- Timeout:
  - MEM_TIMEOUT=4, ready held low for 4 cycles → MemTimeout=1 from the next edge, all stalls stuck at 1 after ready rises.
  - Pulsing rst → all outputs and counters at 0, FSM in RUN.
- Saturation: CNT_W=4, StallF held 20 cycles → StallCount=15 and holds.
